// File: rtl/ringosc_freq_counter_pkg.sv
// Shared types for the ring-oscillator frequency counter.
package ringosc_freq_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Width of a down-counter that must hold n-1 (at least one bit).
  function automatic int gate_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ringosc_freq_counter_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level plus a rising-edge strobe.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/ringosc_freq_counter.sv
// Counts synchronised oscillator rising edges over a GATE_CYCLES clk window
// and holds the saturating result behind a valid/ready handshake.
module ringosc_freq_counter
  import ringosc_freq_counter_pkg::*;
#(
  parameter int GATE_CYCLES = 1024,
  parameter int COUNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   osc_in,
  input  logic                   start,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow,
  output logic                   count_valid,
  input  logic                   count_ready
);

  localparam int                   GW        = gate_width(GATE_CYCLES);
  localparam logic [GW-1:0]        GATE_LOAD = GW'(GATE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [GW-1:0]          gate_q, gate_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   osc_level;
  logic                   osc_rise;

  // Free-running in every state so the window never opens on a stale edge.
  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (osc_in),
    .level    (osc_level),
    .rise     (osc_rise)
  );

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_GATE;
          gate_d  = GATE_LOAD;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_GATE: begin
        if (osc_rise) begin
          if (count_q == CNT_MAX) ovf_d = 1'b1;
          else                    count_d = count_q + COUNT_WIDTH'(1);
        end
        if (gate_q == '0) state_d = ST_HOLD;
        else              gate_d  = gate_q - GW'(1);
      end
      ST_HOLD: begin
        if (count_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gate_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign count_valid = (state_q == ST_HOLD);
  assign count       = count_q;
  assign overflow    = ovf_q;

endmodule
